// File: rtl/piso_ce_driver_if.sv
// Load handshake and serial capture-stage bus for piso_ce_driver.
// master = the side offering words, slave = the serialiser itself.
interface piso_ce_driver_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             flush;
  logic             ser_data;
  logic             ser_enable;
  logic             clr_out;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, flush,
    input  load_ready, ser_data, ser_enable, clr_out, busy, done
  );

  modport slave (
    input  load_valid, load_data, flush,
    output load_ready, ser_data, ser_enable, clr_out, busy, done
  );
endinterface

// File: rtl/piso_ce_driver.sv
// Parallel-in serial-out driver for a latch/flip-flop capture stage.
// Words accepted over valid/ready are shifted out MSB first on ser_data.
// A one-cycle ser_enable strobe occurs every DIV clocks while a word is in flight.
// clr_out holds the capture stage clear for two cycles after every reset.
// All outputs come straight from flops, computed from next-state values.
module piso_ce_driver #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  piso_ce_driver_if.slave      bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_CLR   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t             state_r,     state_s;
  logic [WIDTH-1:0]   shift_r,     shift_s;
  logic [DIV_W-1:0]   div_cnt_r,   div_cnt_s;
  logic [BIT_W-1:0]   bit_cnt_r,   bit_cnt_s;
  logic               clr_cnt_r,   clr_cnt_s;
  logic               done_s;

  logic               ser_data_r,   ser_data_s;
  logic               ser_enable_r, ser_enable_s;
  logic               clr_out_r,    clr_out_s;
  logic               busy_r,       busy_s;
  logic               done_r;
  logic               load_ready_r, load_ready_s;

  // Next-state logic: clear sequencing, word accept, bit timing and flush.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    div_cnt_s = div_cnt_r;
    bit_cnt_s = bit_cnt_r;
    clr_cnt_s = clr_cnt_r;
    done_s    = 1'b0;
    case (state_r)
      ST_CLR: begin
        // flush and load_valid are deliberately ignored while clearing
        if (clr_cnt_r == 1'b1) begin
          state_s   = ST_IDLE;
          clr_cnt_s = 1'b0;
        end else begin
          clr_cnt_s = 1'b1;
        end
      end
      ST_IDLE: begin
        // flush outranks load_valid so no word is taken in a flush cycle
        if (bus.load_valid && !bus.flush) begin
          state_s   = ST_SHIFT;
          shift_s   = bus.load_data;
          div_cnt_s = {DIV_W{1'b0}};
          bit_cnt_s = {BIT_W{1'b0}};
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.flush) begin
          state_s = ST_IDLE;
        end else if (div_cnt_r == DIV_LAST) begin
          // this cycle carried a strobe: advance to the next bit
          shift_s   = {shift_r[WIDTH-2:0], 1'b0};
          div_cnt_s = {DIV_W{1'b0}};
          if (bit_cnt_r == BIT_LAST) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_s = ST_CLR;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain flop.
  always_comb begin
    clr_out_s    = (state_s == ST_CLR);
    load_ready_s = (state_s == ST_IDLE);
    busy_s       = (state_s == ST_SHIFT);
    if (state_s == ST_SHIFT) begin
      ser_data_s   = shift_s[WIDTH-1];
      ser_enable_s = (div_cnt_s == DIV_LAST);
    end else begin
      ser_data_s   = 1'b0;
      ser_enable_s = 1'b0;
    end
  end

  // State, datapath and output registers; reset restarts the clear sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_CLR;
      shift_r      <= {WIDTH{1'b0}};
      div_cnt_r    <= {DIV_W{1'b0}};
      bit_cnt_r    <= {BIT_W{1'b0}};
      clr_cnt_r    <= 1'b0;
      ser_data_r   <= 1'b0;
      ser_enable_r <= 1'b0;
      clr_out_r    <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      load_ready_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      div_cnt_r    <= div_cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      clr_cnt_r    <= clr_cnt_s;
      ser_data_r   <= ser_data_s;
      ser_enable_r <= ser_enable_s;
      clr_out_r    <= clr_out_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      load_ready_r <= load_ready_s;
    end
  end

  assign bus.ser_data   = ser_data_r;
  assign bus.ser_enable = ser_enable_r;
  assign bus.clr_out    = clr_out_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.load_ready = load_ready_r;

endmodule
